tube_readout_ctrl: RTL and testbench
====================================

// Module: tube_readout_ctrl
// PURPOSE
//  Sequences a bank of N_TUBES drift-time tube counters through one measurement frame:
//  arm -> timed gate window -> snapshot -> serial readout -> re-clear.
//  Sits between the trigger logic and the per-tube counters.
//  Drives their shared clear and gate-enable lines and consumes their 8-bit cycle counts.
//  Streams one (index, count, hit) record per tube to the host link over a valid/ready handshake.
// PARAMETERS
//  N_TUBES     8    number of tube counters controlled (1..16)
//  CNT_W       8    width of each tube count
//  WINDOW      200  gate window length in clk cycles (1..2^CNT_W-1)
//  IDX_W       4    width of tube index output (>= clog2(N_TUBES))
// PORTS
//  clk           in   1               system clock, all logic on posedge
//  clr_n         in   1               asynchronous, active-low reset
//  trigger       in   1               start-of-frame request, sampled in IDLE only
//  tube_cnt      in   N_TUBES*CNT_W   tube counts, tube i at [i*CNT_W +: CNT_W]
//  tube_clr      out  1               shared clear to all tube counters/latches (active high)
//  gate_en       out  1               shared gate enable to all tube latches
//  out_valid     out  1               readout record valid
//  out_ready     in   1               downstream accepts record
//  out_idx       out  IDX_W           tube index of current record
//  out_data      out  CNT_W           snapshotted count of tube out_idx
//  out_hit       out  1               1 = tube fired inside window (count < WINDOW)
//  busy          out  1               high in any state except IDLE
//  frame_done    out  1               one-cycle pulse after last record accepted
//  trig_missed   out  1               one-cycle pulse: trigger high while busy (ignored)
// BEHAVIOUR
//  Reset (clr_n=0, async)
//   - Forces state IDLE, regardless of state at the time (mid-frame reset abandons the frame).
//   - Outputs: tube_clr=1, gate_en=0, out_valid=0, out_idx=0, out_data=0, out_hit=0,
//     busy=0, frame_done=0, trig_missed=0.
//   - Clears the window counter and snapshot registers.
//  States
//   - IDLE:
//     - tube_clr=1, gate_en=0.
//     - trigger=1 at edge k -> ARM; from cycle k+1: tube_clr=0, gate_en=1, win_cnt=0.
//   - ARM:
//     - tube_clr=0, gate_en=1.
//     - win_cnt increments once per clk.
//     - On the cycle where win_cnt==WINDOW-1:
//       - at that edge, capture all N_TUBES counts into the snapshot;
//       - go to READ with tube_clr=1, gate_en=0 and idx=0.
//     - ARM therefore lasts exactly WINDOW cycles.
//   - READ:
//     - tube_clr=1, gate_en=0, out_valid=1.
//     - out_idx=idx, out_data=snap[idx], out_hit=(snap[idx] < WINDOW).
//     - Record transfers on a cycle where out_valid & out_ready.
//     - On transfer: idx+1. If idx==N_TUBES-1 -> DONE.
//     - out_valid drops in the cycle after the last transfer.
//     - out_ready=0 holds out_idx, out_data and out_hit stable; back-to-back transfers allowed.
//   - DONE: for one cycle, frame_done=1 and out_valid=0; then IDLE.
//  Rules
//   - Snapshot is immune to tube_cnt changes after capture.
//   - Tubes are held in clear for the whole readout.
//   - trigger while busy=1 -> trig_missed=1 for that cycle; the frame is unaffected, no queueing.
//   - trigger held high across DONE -> IDLE: a new frame starts on the first IDLE cycle it is sampled.
//   - win_cnt width = CNT_W; WINDOW never wraps it.
//   - Comparison is unsigned.
//   - A no-hit tube reads out count >= WINDOW and out_hit=0.
//   - Hits are defined by count value only; the controller does not observe the tube pins.
//   - No combinational path from out_ready to out_valid.
// TESTING
//  1 Reset: clr_n=0 mid-ARM -> immediately tube_clr=1, gate_en=0, busy=0.
//    After release, idle until trigger.
//  2 Frame: WINDOW=200, N_TUBES=8, tube counts 5,17,0,199,200,255,42,100 at capture, out_ready=1.
//    -> gate_en high exactly 200 cycles.
//    -> 8 consecutive records idx 0..7 with matching data.
//    -> hit=1,1,1,1,0,0,1,1.
//    -> frame_done pulse 1 cycle after idx 7.
//  3 Backpressure: out_ready toggled 1-0-0-1 pseudo-randomly.
//    -> each record held stable while stalled; no index skipped or duplicated.
//  4 Trigger during ARM and during READ.
//    -> trig_missed pulses each time; frame length and record count unchanged.
//  5 Snapshot: tube_cnt changes every cycle during READ.
//    -> out_data equals values present at the capture edge.
//  6 Continuous trigger=1.
//    -> back-to-back frames separated by exactly one IDLE cycle after DONE.
//    -> tube_clr high between frames.

Source files
------------

// File: rtl/tube_readout_ctrl.sv
// Frame sequencer for a bank of drift-time tube counters.
// It arms the counters, times the gate window, snapshots the counts and streams one record per tube.
module tube_readout_ctrl #(
  parameter int N_TUBES = 8,
  parameter int CNT_W   = 8,
  parameter int WINDOW  = 200,
  parameter int IDX_W   = 4
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     trigger,
  input  logic [N_TUBES*CNT_W-1:0] tube_cnt,
  output logic                     tube_clr,
  output logic                     gate_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic [CNT_W-1:0]         out_data,
  output logic                     out_hit,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     trig_missed
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_READ = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] WIN_LIM  = CNT_W'(WINDOW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_TUBES - 1);

  state_t           state_r;
  logic [CNT_W-1:0] win_cnt_r;
  logic [CNT_W-1:0] snap_r [N_TUBES];
  logic [IDX_W-1:0] next_idx_s;
  logic [CNT_W-1:0] next_data_s;

  // A trigger is flagged in the very cycle it is seen while a frame is in progress.
  assign trig_missed = trigger & busy;

  // Select the snapshot entry for the record that follows the current one.
  always_comb begin
    next_idx_s  = out_idx + IDX_W'(1);
    next_data_s = '0;
    for (int i = 0; i < N_TUBES; i++) begin
      next_data_s = (IDX_W'(i) == next_idx_s) ? snap_r[i] : next_data_s;
    end
  end

  // Frame sequencer with all outputs registered.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_r    <= ST_IDLE;
      win_cnt_r  <= '0;
      tube_clr   <= 1'b1;
      gate_en    <= 1'b0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
      out_hit    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < N_TUBES; i++) begin
        snap_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          frame_done <= 1'b0;
          if (trigger) begin
            state_r   <= ST_ARM;
            win_cnt_r <= '0;
            tube_clr  <= 1'b0;
            gate_en   <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_ARM: begin
          if (win_cnt_r == WIN_LAST) begin
            // The first record is taken straight from the bus since the snapshot lands on this edge.
            for (int i = 0; i < N_TUBES; i++) begin
              snap_r[i] <= tube_cnt[i*CNT_W +: CNT_W];
            end
            state_r   <= ST_READ;
            tube_clr  <= 1'b1;
            gate_en   <= 1'b0;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_data  <= tube_cnt[CNT_W-1:0];
            out_hit   <= (tube_cnt[CNT_W-1:0] < WIN_LIM);
          end else begin
            win_cnt_r <= win_cnt_r + CNT_W'(1);
          end
        end
        ST_READ: begin
          if (out_ready) begin
            if (out_idx == IDX_LAST) begin
              state_r    <= ST_DONE;
              out_valid  <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              out_idx  <= next_idx_s;
              out_data <= next_data_s;
              out_hit  <= (next_data_s < WIN_LIM);
            end
          end
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          tube_clr   <= 1'b1;
          gate_en    <= 1'b0;
          out_valid  <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tube_readout_ctrl.sv
// Bench for tube_readout_ctrl: random frames checked against a transaction-level model
// (gate length, captured counts, record order, hit rule, handshake and pulses).
module tb_tube_readout_ctrl;
  localparam int N_TUBES = 8;
  localparam int CNT_W   = 8;
  localparam int WINDOW  = 200;
  localparam int IDX_W   = 4;
  localparam int FIX [N_TUBES] = '{5, 17, 0, 199, 200, 255, 42, 100};

  logic                     clk = 1'b0;
  logic                     clr_n;
  logic                     trigger;
  logic [N_TUBES*CNT_W-1:0] tube_cnt;
  logic                     tube_clr;
  logic                     gate_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDX_W-1:0]         out_idx;
  logic [CNT_W-1:0]         out_data;
  logic                     out_hit;
  logic                     busy;
  logic                     frame_done;
  logic                     trig_missed;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tube_readout_ctrl #(.N_TUBES(N_TUBES), .CNT_W(CNT_W), .WINDOW(WINDOW), .IDX_W(IDX_W)) dut (
    .clk(clk), .clr_n(clr_n), .trigger(trigger), .tube_cnt(tube_cnt),
    .tube_clr(tube_clr), .gate_en(gate_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_data(out_data), .out_hit(out_hit), .busy(busy),
    .frame_done(frame_done), .trig_missed(trig_missed)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CNT_W-1:0] rand_cnt();
    case ($urandom_range(0, 4))
      0:       return CNT_W'(WINDOW - 1);
      1:       return CNT_W'(WINDOW);
      2:       return '0;
      3:       return '1;
      default: return CNT_W'($urandom);
    endcase
  endfunction

  task automatic drive_random_cnt();
    for (int i = 0; i < N_TUBES; i++) tube_cnt[i*CNT_W +: CNT_W] = rand_cnt();
  endtask

  // One whole frame from an IDLE cycle back to the following IDLE cycle.
  task automatic run_frame(input bit bp, input bit noise, input bit fixed, input bit hold, input string tag);
    logic [CNT_W-1:0] cap [N_TUBES];
    int gate_cnt;
    int exp_i;
    int rd_cyc;
    bit rdy;
    logic exp_hit;
    trigger = 1'b1;
    #1;
    checks++;
    if (trig_missed !== 1'b0) begin
      errors++; $display("FAIL %s idle_trig_missed: got %b expected 0", tag, trig_missed);
    end
    tick();
    trigger = hold;
    checks++;
    if ({gate_en, tube_clr, busy, out_valid} !== 4'b1010) begin
      errors++; $display("FAIL %s arm_entry gate/clr/busy/valid: got %b expected 1010", tag, {gate_en, tube_clr, busy, out_valid});
    end
    gate_cnt = 0;
    while (gate_en === 1'b1 && gate_cnt < WINDOW + 4) begin
      gate_cnt++;
      if (fixed) begin
        for (int i = 0; i < N_TUBES; i++) tube_cnt[i*CNT_W +: CNT_W] = CNT_W'(FIX[i]);
      end else begin
        drive_random_cnt();
      end
      for (int i = 0; i < N_TUBES; i++) cap[i] = tube_cnt[i*CNT_W +: CNT_W];
      trigger = hold | (noise & ($urandom_range(0, 7) == 0));
      #1;
      checks++;
      if (trig_missed !== trigger || tube_clr !== 1'b0) begin
        errors++; $display("FAIL %s arm trig_missed/tube_clr: got %b%b expected %b0", tag, trig_missed, tube_clr, trigger);
      end
      tick();
    end
    checks++;
    if (gate_cnt != WINDOW) begin
      errors++; $display("FAIL %s gate_len: got %0d expected %0d", tag, gate_cnt, WINDOW);
    end
    exp_i = 0;
    rd_cyc = 0;
    while (exp_i < N_TUBES && rd_cyc < 64 * N_TUBES) begin
      rd_cyc++;
      exp_hit = (int'(cap[exp_i]) < WINDOW);
      checks++;
      if ({out_valid, tube_clr, gate_en, busy} !== 4'b1101) begin
        errors++; $display("FAIL %s read valid/clr/gate/busy: got %b expected 1101", tag, {out_valid, tube_clr, gate_en, busy});
      end
      checks++;
      if (out_idx !== IDX_W'(exp_i)) begin
        errors++; $display("FAIL %s out_idx: got %0d expected %0d", tag, out_idx, exp_i);
      end
      checks++;
      if (out_data !== cap[exp_i]) begin
        errors++; $display("FAIL %s out_data[%0d]: got %0d expected %0d", tag, exp_i, out_data, cap[exp_i]);
      end
      checks++;
      if (out_hit !== exp_hit) begin
        errors++; $display("FAIL %s out_hit[%0d]: got %b expected %b", tag, exp_i, out_hit, exp_hit);
      end
      rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      drive_random_cnt();
      trigger = hold | (noise & ($urandom_range(0, 3) == 0));
      #1;
      checks++;
      if (trig_missed !== trigger) begin
        errors++; $display("FAIL %s read_trig_missed: got %b expected %b", tag, trig_missed, trigger);
      end
      tick();
      if (rdy) exp_i++;
    end
    if (exp_i < N_TUBES) begin
      errors++; $display("FAIL %s read_timeout: got %0d records expected %0d", tag, exp_i, N_TUBES);
    end
    if (!bp) begin
      checks++;
      if (rd_cyc != N_TUBES) begin
        errors++; $display("FAIL %s read_cycles: got %0d expected %0d", tag, rd_cyc, N_TUBES);
      end
    end
    out_ready = 1'b0;
    trigger = hold;
    checks++;
    if ({out_valid, frame_done, busy, tube_clr} !== 4'b0111) begin
      errors++; $display("FAIL %s done valid/done/busy/clr: got %b expected 0111", tag, {out_valid, frame_done, busy, tube_clr});
    end
    #1;
    checks++;
    if (trig_missed !== hold) begin
      errors++; $display("FAIL %s done_trig_missed: got %b expected %b", tag, trig_missed, hold);
    end
    tick();
    checks++;
    if ({busy, frame_done, tube_clr, gate_en, trig_missed} !== 5'b00100) begin
      errors++; $display("FAIL %s idle busy/done/clr/gate/missed: got %b expected 00100", tag, {busy, frame_done, tube_clr, gate_en, trig_missed});
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    trigger = 1'b0;
    out_ready = 1'b0;
    tube_cnt = '0;
    tick();
    tick();
    checks++;
    if ({tube_clr, gate_en, out_valid, out_hit, busy, frame_done, trig_missed} !== 7'b1000000
        || out_idx !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_values: got %b idx=%0d data=%0d expected 1000000 idx=0 data=0",
        {tube_clr, gate_en, out_valid, out_hit, busy, frame_done, trig_missed}, out_idx, out_data);
    end
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({busy, tube_clr, gate_en} !== 3'b010) begin
        errors++; $display("FAIL reset_idle: got %b expected 010", {busy, tube_clr, gate_en});
      end
    end
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    checks++;
    if ({busy, gate_en} !== 2'b11) begin
      errors++; $display("FAIL reset_pre_arm: got %b expected 11", {busy, gate_en});
    end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({tube_clr, gate_en, busy} !== 3'b100) begin
      errors++; $display("FAIL reset_mid_arm: got %b expected 100", {tube_clr, gate_en, busy});
    end
    tick();
    clr_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({busy, gate_en, out_valid, tube_clr} !== 4'b0001) begin
        errors++; $display("FAIL reset_after_release: got %b expected 0001", {busy, gate_en, out_valid, tube_clr});
      end
    end
  endtask

  task automatic test_frame();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, "frame");
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 2; i++) run_frame(1'b1, 1'b0, 1'b0, 1'b0, "backpressure");
  endtask

  task automatic test_trig_missed();
    run_frame(1'b1, 1'b1, 1'b0, 1'b0, "trig_missed");
  endtask

  task automatic test_snapshot();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, "snapshot");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0, 1'b1, "back_to_back");
    trigger = 1'b0;
    tick();
    checks++;
    if ({busy, gate_en, tube_clr} !== 3'b001) begin
      errors++; $display("FAIL b2b_stop: got %b expected 001", {busy, gate_en, tube_clr});
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_trig_missed();
    test_snapshot();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
